i2s_tx: RTL
===========

# i2s_tx

Serial audio transmitter for the DAC path: accepts a stereo pair of 24-bit two's-complement samples (left/right, typically post-gain) over a valid/ready handshake. Emits a standard I2S stream (BCLK, LRCK, serial data) to the codec. Sits directly downstream of the gain stage and is the last block before the codec pins. Generates its own bit clock from the system clock; one stereo frame is 64 BCLK periods (32 slots per channel).

## Interface
- BCLK_DIV, 8, system clocks per BCLK half-period; legal range 1..255 (50 MHz / 16 = 3.125 MHz BCLK, 48.8 kHz frame)
- clk_i  in  1  system clock
- rst_i  in  1  reset, asynchronous, active-high
- left_i  in  24  left sample, two's complement
- right_i  in  24  right sample, two's complement
- valid_i  in  1  left_i/right_i pair is valid
- ready_o  out  1  holding register empty; pair accepted on valid_i && ready_o at a rising clk_i
- bclk_o  out  1  I2S bit clock
- lrck_o  out  1  word select: 0 = left slot half, 1 = right slot half
- dat_o  out  1  I2S serial data, MSB first
- underrun_o  out  1  one-clk_i pulse: frame started with no pair buffered

## Operation
- Single clock domain: bclk_o/lrck_o/dat_o are registers in clk_i; no derived clocks used internally.
- Divider: div_cnt counts 0..BCLK_DIV-1; at terminal count it wraps to 0 and bclk_o toggles. Toggle to 0 = "BCLK falling event".
- Slot counter bit_cnt (6 bits) increments on each falling event, wrapping 63 -> 0. lrck_o = next bit_cnt[5], updated on the same falling event.
- Holding register (1 pair): loads on valid_i && ready_o; sets full; ready_o = ~full. A pair offered while full is not accepted; upstream must hold it stable.
- Frame load: on the falling event where bit_cnt wraps 63 -> 0:
  - full = 1: copy pair into left/right shift registers; clear full.
  - full = 0: shift registers load zeros; underrun_o pulses for that clk_i cycle.
  - Acceptance and frame load in the same cycle: the load takes the old buffered pair (or zeros). The new pair is written into the holding register, so full stays set.
- dat_o per slot s (set on falling event entering slot s):
  - s = 0 or 32: 0 (one-BCLK I2S delay)
  - s = 1..24: left[24-s]
  - s = 33..56: right[56-s]
  - s = 25..31, 57..63: 0
- Codec samples dat_o and lrck_o on BCLK rising edge; both only change on falling events.
- No saturation or format conversion; bits pass through unchanged.

## Timing
- Reset values: bclk_o=0, lrck_o=1, dat_o=0, ready_o=1, underrun_o=0, div_cnt=0, bit_cnt=63, full=0, shift registers 0.
- First event after reset is a rising BCLK; the following falling event (2*BCLK_DIV clk_i after reset release) wraps bit_cnt to 0 and performs the first frame load. If no pair has been accepted by then, underrun_o pulses.
- BCLK period = 2*BCLK_DIV clk_i; frame = 128*BCLK_DIV clk_i.
- Latency: pair accepted at cycle T. Its left MSB appears on dat_o one BCLK after the next frame-load event. Its right MSB appears 33 BCLKs after that event.
- ready_o deasserts the cycle after acceptance and reasserts the cycle after the frame load that consumes the pair.
- Async reset mid-frame: all state returns to reset values immediately; the partial frame is dropped and the buffered pair is discarded.

## Test plan
- Reset, BCLK_DIV=2: bclk_o toggles every 2 clk_i (period 4). lrck_o low for 32 BCLKs then high for 32. ready_o=1. underrun_o pulses once per frame with dat_o constantly 0.
- Single pair left=24'hA5F00F, right=24'h5A0FF0 accepted before first frame load: deserialize dat_o on BCLK rising edges. Slots 1..24 = A5F00F, slots 33..56 = 5A0FF0, all other slots 0, no underrun.
- Back-to-back streaming: valid_i held high with incrementing pairs. Exactly one pair accepted per frame; no underrun; the sequence is reproduced in order; ready_o low about 1 frame per pair.
- Extremes: left=24'h800000, right=24'h7FFFFF: bits are serialized exactly (1 followed by 23 zeros; 0 followed by 23 ones).
- Acceptance coincident with frame-load cycle: the old pair is transmitted; the new pair is transmitted the next frame; full stays 1 across that cycle.
- Assert rst_i at slot 40 with a pair buffered: outputs go to reset values asynchronously. After release, the first frame is zeros with an underrun_o pulse.

Source files
------------

// File: rtl/i2s_tx.sv
// rtl/i2s_tx.sv - I2S transmitter: one-pair holding register, 64-slot stereo frame, BCLK divided from clk_i
module i2s_tx #(
    parameter int unsigned BCLK_DIV = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [23:0] left_i,
    input  logic [23:0] right_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic        bclk_o,
    output logic        lrck_o,
    output logic        dat_o,
    output logic        underrun_o
);

    logic [7:0]  r_div_cnt;
    logic        r_bclk;
    logic        r_lrck;
    logic        r_dat;
    logic        r_underrun;
    logic        r_full;
    logic [5:0]  r_bit_cnt;
    logic [23:0] r_hold_l;
    logic [23:0] r_hold_r;
    logic [23:0] r_shift_l;
    logic [23:0] r_shift_r;

    logic        w_tc;
    logic        w_fall;
    logic        w_load;
    logic        w_accept;
    logic [5:0]  w_next;
    logic [4:0]  w_idx;
    logic        w_in_data;
    logic        w_bit;

    assign w_tc     = (r_div_cnt == 8'(BCLK_DIV - 1));
    assign w_fall   = w_tc && r_bclk;
    assign w_load   = w_fall && (r_bit_cnt == 6'd63);
    assign w_accept = valid_i && !r_full;
    assign w_next   = r_bit_cnt + 6'd1;

    // Both channel halves share the slot-within-half arithmetic: slots 1..24 carry bits 23..0.
    assign w_idx     = 5'd24 - w_next[4:0];
    assign w_in_data = (w_next[4:0] != 5'd0) && (w_next[4:0] <= 5'd24);
    assign w_bit     = w_next[5] ? r_shift_r[w_idx] : r_shift_l[w_idx];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_div_cnt  <= 8'd0;
            r_bclk     <= 1'b0;
            r_lrck     <= 1'b1;
            r_dat      <= 1'b0;
            r_underrun <= 1'b0;
            r_full     <= 1'b0;
            r_bit_cnt  <= 6'd63;
            r_hold_l   <= 24'd0;
            r_hold_r   <= 24'd0;
            r_shift_l  <= 24'd0;
            r_shift_r  <= 24'd0;
        end else begin
            r_underrun <= 1'b0;
            if (w_tc) begin
                r_div_cnt <= 8'd0;
                r_bclk    <= !r_bclk;
            end else begin
                r_div_cnt <= r_div_cnt + 8'd1;
            end

            if (w_fall) begin
                r_bit_cnt <= w_next;
                r_lrck    <= w_next[5];
                r_dat     <= w_in_data ? w_bit : 1'b0;
            end

            // Frame load takes whatever was buffered before this edge; a same-cycle accept refills.
            if (w_load) begin
                r_shift_l  <= r_full ? r_hold_l : 24'd0;
                r_shift_r  <= r_full ? r_hold_r : 24'd0;
                r_underrun <= !r_full;
            end

            if (w_accept) begin
                r_hold_l <= left_i;
                r_hold_r <= right_i;
                r_full   <= 1'b1;
            end else if (w_load) begin
                r_full <= 1'b0;
            end
        end
    end

    assign ready_o    = !r_full;
    assign bclk_o     = r_bclk;
    assign lrck_o     = r_lrck;
    assign dat_o      = r_dat;
    assign underrun_o = r_underrun;

endmodule
